// File: rtl/rv32i_pkg.sv
// Shared RV32I execute-side definitions: ALU control codes, operand selects
// and the ID/EX stage record with its bubble value.
package rv32i_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_XOR  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_AND  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001,
        ALU_THRU = 4'b1111
    } alu_ctrl_e;

    localparam logic SRC1_RS1 = 1'b0;
    localparam logic SRC1_PC  = 1'b1;
    localparam logic SRC2_RS2 = 1'b0;
    localparam logic SRC2_IMM = 1'b1;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [4:0]  rd_addr;
        logic        reg_write;
        logic        mem_read;
        logic [3:0]  alu_ctrl;
        logic        src1_sel;
        logic        src2_sel;
    } ex_stage_t;

    localparam ex_stage_t EX_BUBBLE = '{
        valid:     1'b0,
        pc:        32'd0,
        imm:       32'd0,
        rs1_addr:  5'd0,
        rs2_addr:  5'd0,
        rs1_data:  32'd0,
        rs2_data:  32'd0,
        rd_addr:   5'd0,
        reg_write: 1'b0,
        mem_read:  1'b0,
        alu_ctrl:  ALU_ADD,
        src1_sel:  SRC1_RS1,
        src2_sel:  SRC2_RS2
    };

endpackage

// File: rtl/fwd_mux.sv
// Resolves one register operand from the MEM and WB bypass paths,
// falling back to the value captured from the register file.
module fwd_mux (
    input  logic [4:0]  addr,
    input  logic [31:0] reg_data,
    input  logic        mem_we,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_data,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic [31:0] operand
);

    // x0 is hardwired zero, so a bypass targeting it must never leak through.
    always_comb begin
        if (addr == 5'd0) begin
            operand = 32'd0;
        end else if (mem_we && (mem_rd == addr)) begin
            operand = mem_data;
        end else if (wb_we && (wb_rd == addr)) begin
            operand = wb_data;
        end else begin
            operand = reg_data;
        end
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding and load-use detection;
// presents resolved ALU operands and store data to the execute stage.
module ex_operand_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_rs1_addr,
    input  logic [4:0]  id_rs2_addr,
    input  logic [31:0] id_rs1_data,
    input  logic [31:0] id_rs2_data,
    input  logic [4:0]  id_rd_addr,
    input  logic        id_reg_write,
    input  logic        id_mem_read,
    input  logic [3:0]  id_alu_ctrl,
    input  logic        id_src1_sel,
    input  logic        id_src2_sel,
    input  logic        stall,
    input  logic        flush,
    input  logic        mem_fwd_we,
    input  logic [4:0]  mem_fwd_rd,
    input  logic [31:0] mem_fwd_data,
    input  logic        wb_fwd_we,
    input  logic [4:0]  wb_fwd_rd,
    input  logic [31:0] wb_fwd_data,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [4:0]  ex_rd_addr,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic [3:0]  ex_alu_ctrl,
    output logic [31:0] ex_src1,
    output logic [31:0] ex_src2,
    output logic [31:0] ex_store_data,
    output logic        id_hold
);
    import rv32i_pkg::*;

    ex_stage_t   q;
    ex_stage_t   id_entry;
    logic [31:0] rs1_fwd;
    logic [31:0] rs2_fwd;

    fwd_mux u_fwd_rs1 (
        .addr     (q.rs1_addr),
        .reg_data (q.rs1_data),
        .mem_we   (mem_fwd_we),
        .mem_rd   (mem_fwd_rd),
        .mem_data (mem_fwd_data),
        .wb_we    (wb_fwd_we),
        .wb_rd    (wb_fwd_rd),
        .wb_data  (wb_fwd_data),
        .operand  (rs1_fwd)
    );

    fwd_mux u_fwd_rs2 (
        .addr     (q.rs2_addr),
        .reg_data (q.rs2_data),
        .mem_we   (mem_fwd_we),
        .mem_rd   (mem_fwd_rd),
        .mem_data (mem_fwd_data),
        .wb_we    (wb_fwd_we),
        .wb_rd    (wb_fwd_rd),
        .wb_data  (wb_fwd_data),
        .operand  (rs2_fwd)
    );

    always_comb begin
        // NOTE: start from a full default so every field is assigned on every path; no latch.
        id_entry           = EX_BUBBLE;
        id_entry.valid     = id_valid;
        id_entry.pc        = id_pc;
        id_entry.imm       = id_imm;
        id_entry.rs1_addr  = id_rs1_addr;
        id_entry.rs2_addr  = id_rs2_addr;
        id_entry.rs1_data  = id_rs1_data;
        id_entry.rs2_data  = id_rs2_data;
        id_entry.rd_addr   = id_rd_addr;
        id_entry.reg_write = id_valid & id_reg_write;
        id_entry.mem_read  = id_valid & id_mem_read;
        id_entry.alu_ctrl  = id_alu_ctrl;
        id_entry.src1_sel  = id_src1_sel;
        id_entry.src2_sel  = id_src2_sel;
    end

    // Conservative: both source addresses are compared even if one is unused.
    assign id_hold = q.valid && q.mem_read && (q.rd_addr != 5'd0) && id_valid &&
                     ((q.rd_addr == id_rs1_addr) || (q.rd_addr == id_rs2_addr));

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every field updates from pre-edge values.
        if (rst) begin
            q <= EX_BUBBLE;
        end else if (flush) begin
            q <= EX_BUBBLE;
        end else if (stall) begin
            // Refresh held operands so a result retiring during the stall survives.
            q.rs1_data <= rs1_fwd;
            q.rs2_data <= rs2_fwd;
        end else if (id_hold) begin
            q <= EX_BUBBLE;
        end else begin
            q <= id_entry;
        end
    end

    assign ex_valid      = q.valid;
    assign ex_pc         = q.pc;
    assign ex_rd_addr    = q.rd_addr;
    assign ex_reg_write  = q.reg_write;
    assign ex_mem_read   = q.mem_read;
    assign ex_alu_ctrl   = q.alu_ctrl;
    assign ex_src1       = (q.src1_sel == SRC1_PC)  ? q.pc  : rs1_fwd;
    assign ex_src2       = (q.src2_sel == SRC2_IMM) ? q.imm : rs2_fwd;
    assign ex_store_data = rs2_fwd;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage: directed scenarios followed by
// random traffic, all compared against a behavioural model of the stage.
module tb_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_pc, id_imm, id_rs1_data, id_rs2_data;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic        id_reg_write, id_mem_read, id_src1_sel, id_src2_sel;
    logic [3:0]  id_alu_ctrl;
    logic        stall, flush;
    logic        mem_fwd_we, wb_fwd_we;
    logic [4:0]  mem_fwd_rd, wb_fwd_rd;
    logic [31:0] mem_fwd_data, wb_fwd_data;
    logic        ex_valid, ex_reg_write, ex_mem_read, id_hold;
    logic [31:0] ex_pc, ex_src1, ex_src2, ex_store_data;
    logic [4:0]  ex_rd_addr;
    logic [3:0]  ex_alu_ctrl;

    always #5 clk = ~clk;

    ex_operand_stage dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_pc         (id_pc),
        .id_imm        (id_imm),
        .id_rs1_addr   (id_rs1_addr),
        .id_rs2_addr   (id_rs2_addr),
        .id_rs1_data   (id_rs1_data),
        .id_rs2_data   (id_rs2_data),
        .id_rd_addr    (id_rd_addr),
        .id_reg_write  (id_reg_write),
        .id_mem_read   (id_mem_read),
        .id_alu_ctrl   (id_alu_ctrl),
        .id_src1_sel   (id_src1_sel),
        .id_src2_sel   (id_src2_sel),
        .stall         (stall),
        .flush         (flush),
        .mem_fwd_we    (mem_fwd_we),
        .mem_fwd_rd    (mem_fwd_rd),
        .mem_fwd_data  (mem_fwd_data),
        .wb_fwd_we     (wb_fwd_we),
        .wb_fwd_rd     (wb_fwd_rd),
        .wb_fwd_data   (wb_fwd_data),
        .ex_valid      (ex_valid),
        .ex_pc         (ex_pc),
        .ex_rd_addr    (ex_rd_addr),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_alu_ctrl   (ex_alu_ctrl),
        .ex_src1       (ex_src1),
        .ex_src2       (ex_src2),
        .ex_store_data (ex_store_data),
        .id_hold       (id_hold)
    );

    // Model of the instruction currently sitting in EX.
    typedef struct {
        logic        valid;
        logic [31:0] pc, imm, rs1d, rs2d;
        logic [4:0]  rs1a, rs2a, rd;
        logic        rw, mr, s1, s2;
        logic [3:0]  alu;
    } mstate_t;

    mstate_t m, m_next;
    int n_cmp  = 0;
    int n_fail = 0;

    function automatic mstate_t bubble();
        mstate_t b;
        b.valid = 0; b.pc = 0; b.imm = 0; b.rs1d = 0; b.rs2d = 0;
        b.rs1a = 0; b.rs2a = 0; b.rd = 0; b.rw = 0; b.mr = 0;
        b.s1 = 0; b.s2 = 0; b.alu = 4'b0000;
        return b;
    endfunction

    function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] d);
        if (a == 0) return 32'd0;
        if (mem_fwd_we && mem_fwd_rd == a) return mem_fwd_data;
        if (wb_fwd_we && wb_fwd_rd == a) return wb_fwd_data;
        return d;
    endfunction

    function automatic logic exp_hold();
        return m.valid && m.mr && (m.rd != 0) && id_valid &&
               (m.rd == id_rs1_addr || m.rd == id_rs2_addr);
    endfunction

    function automatic mstate_t model_next();
        mstate_t n = m;
        if (rst || flush) begin
            n = bubble();
        end else if (stall) begin
            n.rs1d = fwd(m.rs1a, m.rs1d);
            n.rs2d = fwd(m.rs2a, m.rs2d);
        end else if (exp_hold()) begin
            n = bubble();
        end else begin
            n.valid = id_valid;     n.pc   = id_pc;       n.imm  = id_imm;
            n.rs1a  = id_rs1_addr;  n.rs2a = id_rs2_addr;
            n.rs1d  = id_rs1_data;  n.rs2d = id_rs2_data; n.rd   = id_rd_addr;
            n.rw    = id_valid && id_reg_write;
            n.mr    = id_valid && id_mem_read;
            n.alu   = id_alu_ctrl;  n.s1   = id_src1_sel; n.s2   = id_src2_sel;
        end
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        #1;
        check({tag, ".valid"}, 32'(ex_valid),      32'(m.valid));
        check({tag, ".pc"},    ex_pc,              m.pc);
        check({tag, ".rd"},    32'(ex_rd_addr),    32'(m.rd));
        check({tag, ".rw"},    32'(ex_reg_write),  32'(m.rw));
        check({tag, ".mr"},    32'(ex_mem_read),   32'(m.mr));
        check({tag, ".alu"},   32'(ex_alu_ctrl),   32'(m.alu));
        check({tag, ".src1"},  ex_src1,  m.s1 ? m.pc  : fwd(m.rs1a, m.rs1d));
        check({tag, ".src2"},  ex_src2,  m.s2 ? m.imm : fwd(m.rs2a, m.rs2d));
        check({tag, ".store"}, ex_store_data, fwd(m.rs2a, m.rs2d));
        check({tag, ".hold"},  32'(id_hold),       32'(exp_hold()));
    endtask

    task automatic tick();
        m_next = model_next();
        @(posedge clk);
        m = m_next;
        @(negedge clk);
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc, input logic [31:0] imm,
                          input logic [4:0] r1, input logic [4:0] r2,
                          input logic [31:0] d1, input logic [31:0] d2,
                          input logic [4:0] rd, input logic rw, input logic mr,
                          input logic [3:0] alu, input logic s1, input logic s2);
        id_valid = v; id_pc = pc; id_imm = imm; id_rs1_addr = r1; id_rs2_addr = r2;
        id_rs1_data = d1; id_rs2_data = d2; id_rd_addr = rd; id_reg_write = rw;
        id_mem_read = mr; id_alu_ctrl = alu; id_src1_sel = s1; id_src2_sel = s2;
    endtask

    task automatic set_fwd(input logic mwe, input logic [4:0] mrd, input logic [31:0] md,
                           input logic wwe, input logic [4:0] wrd, input logic [31:0] wd);
        mem_fwd_we = mwe; mem_fwd_rd = mrd; mem_fwd_data = md;
        wb_fwd_we  = wwe; wb_fwd_rd  = wrd; wb_fwd_data  = wd;
    endtask

    initial begin
        m = bubble();
        rst = 1; stall = 0; flush = 0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0);
        set_fwd(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        tick();
        tick();
        rst = 0;
        check_all("reset");
        check("reset_alu", 32'(ex_alu_ctrl), 32'h0);
        check("reset_valid", 32'(ex_valid), 32'h0);

        // Plain load: rs1 data and immediate pass through.
        set_id(1, 32'h100, 32'd7, 5'd1, 5'd2, 32'd5, 32'd9, 5'd3, 1, 0, 4'b0000, 0, 1);
        tick();
        #1;
        check("plain_src1", ex_src1, 32'd5);
        check("plain_src2", ex_src2, 32'd7);
        check("plain_valid", 32'(ex_valid), 32'd1);
        check_all("plain");

        // MEM bypass beats WB bypass.
        set_id(1, 32'h104, 32'd0, 5'd3, 5'd4, 32'h1111, 32'h2222, 5'd6, 1, 0, 4'b0001, 0, 0);
        tick();
        set_fwd(1, 5'd3, 32'hAAAA, 1, 5'd3, 32'hBBBB);
        #1 check("prio_mem", ex_src1, 32'hAAAA);
        mem_fwd_we = 0;
        #1 check("prio_wb", ex_src1, 32'hBBBB);
        check_all("prio");

        // x0 never forwards.
        set_fwd(0, 0, 0, 0, 0, 0);
        set_id(1, 32'h108, 32'd0, 5'd1, 5'd0, 32'h0, 32'h1234, 5'd0, 0, 0, 4'b0000, 0, 0);
        tick();
        set_fwd(1, 5'd0, 32'hFFFF, 0, 0, 0);
        #1 check("x0_store", ex_store_data, 32'd0);
        check("x0_src2", ex_src2, 32'd0);
        check_all("x0");

        // Load-use bubble then replay of the held instruction.
        set_fwd(0, 0, 0, 0, 0, 0);
        set_id(1, 32'h10C, 32'h10, 5'd1, 5'd2, 32'd0, 32'd0, 5'd5, 1, 1, 4'b0000, 0, 1);
        tick();
        set_id(1, 32'h200, 32'd0, 5'd5, 5'd6, 32'h77, 32'h88, 5'd8, 1, 0, 4'b0011, 0, 0);
        #1 check("lu_hold", 32'(id_hold), 32'd1);
        check_all("lu_pre");
        tick();
        #1 check("lu_bubble_valid", 32'(ex_valid), 32'd0);
        check("lu_bubble_rw", 32'(ex_reg_write), 32'd0);
        check_all("lu_bubble");
        tick();
        #1 check("lu_replay_pc", ex_pc, 32'h200);
        check("lu_replay_valid", 32'(ex_valid), 32'd1);
        check_all("lu_replay");

        // Stall refresh captures a WB result seen only in the first stall cycle.
        set_id(1, 32'h300, 32'd0, 5'd7, 5'd0, 32'h11, 32'd0, 5'd9, 1, 0, 4'b0000, 0, 0);
        tick();
        stall = 1;
        set_id(1, 32'h400, 32'd1, 5'd2, 5'd3, 32'h1, 32'h2, 5'd4, 1, 0, 4'b0010, 0, 0);
        set_fwd(0, 0, 0, 1, 5'd7, 32'h55);
        check_all("stall1");
        tick();
        set_fwd(0, 0, 0, 0, 0, 0);
        check_all("stall2");
        tick();
        #1 check("stall_src1", ex_src1, 32'h55);
        check("stall_pc", ex_pc, 32'h300);
        stall = 0;
        check_all("stall_end");

        // Flush with stall gives a bubble; reset beats flush.
        stall = 1; flush = 1;
        tick();
        #1 check("fs_valid", 32'(ex_valid), 32'd0);
        check("fs_alu", 32'(ex_alu_ctrl), 32'd0);
        stall = 0; flush = 0;
        set_id(1, 32'h500, 32'h9, 5'd1, 5'd2, 32'd3, 32'd4, 5'd10, 1, 1, 4'b0111, 1, 1);
        tick();
        check_all("pre_rst");
        rst = 1; flush = 1;
        tick();
        rst = 0; flush = 0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0);
        #1;
        check("rst_src1", ex_src1, 32'd0);
        check("rst_src2", ex_src2, 32'd0);
        check("rst_store", ex_store_data, 32'd0);
        check("rst_pc", ex_pc, 32'd0);
        check("rst_alu", 32'(ex_alu_ctrl), 32'd0);
        check("rst_mr", 32'(ex_mem_read), 32'd0);
        check_all("rst");

        // Random traffic with small register indices to exercise bypass collisions.
        for (int i = 0; i < 400; i++) begin
            rst   = ($urandom_range(0, 49) == 0);
            flush = ($urandom_range(0, 11) == 0);
            stall = ($urandom_range(0, 5) == 0);
            set_id(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   $urandom, $urandom, 5'($urandom_range(0, 7)),
                   1'($urandom), 1'($urandom_range(0, 2) == 0), 4'($urandom),
                   1'($urandom), 1'($urandom));
            set_fwd(1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                    1'($urandom), 5'($urandom_range(0, 7)), $urandom);
            check_all("rand");
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_operand_stage.md
EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have ports id_valid (1), id_pc (32), id_imm (32), id_rs1_addr (5), id_rs2_addr (5), id_rs1_data (32), id_rs2_data (32), id_rd_addr (5), id_reg_write (1), id_mem_read (1), id_alu_ctrl (4), id_src1_sel (1: 0=rs1, 1=pc), id_src2_sel (1: 0=rs2, 1=imm), all inputs, forming the decoded instruction from ID.
REQ-004 SHALL have inputs stall (1) and flush (1) from the pipeline controller.
REQ-005 SHALL have inputs mem_fwd_we (1), mem_fwd_rd (5), mem_fwd_data (32), wb_fwd_we (1), wb_fwd_rd (5) and wb_fwd_data (32), which are the EX/MEM and MEM/WB forwarding sources.
REQ-006 SHALL have outputs ex_valid (1), ex_pc (32), ex_rd_addr (5), ex_reg_write (1), ex_mem_read (1), ex_alu_ctrl (4), ex_src1 (32), ex_src2 (32) and ex_store_data (32) feeding the ALU and later stages.
REQ-007 SHALL have output id_hold (1), which requests that IF/ID hold its contents during a load-use bubble.

Function
REQ-008 SHALL register ID fields into the stage with 1-cycle latency.
- ex_* fields change only on a clk edge.
- Forwarding onto ex_src1, ex_src2 and ex_store_data is combinational from the registered fields.
REQ-009 SHALL resolve each operand (rs1 and rs2) with this priority:
- MEM source if mem_fwd_we=1, mem_fwd_rd==addr and addr!=0;
- else WB source under the same rule;
- else the registered register-file data.
REQ-010 SHALL force a forwarded operand to 0 when its register address is 0, regardless of the registered data.
REQ-011 SHALL drive ex_src1 from ex_pc when src1_sel=1, otherwise from forwarded rs1.
REQ-012 SHALL drive ex_src2 from the registered imm when src2_sel=1, otherwise from forwarded rs2.
REQ-013 SHALL always drive ex_store_data from forwarded rs2, independent of src2_sel.
REQ-014 SHALL assert id_hold combinationally when all of the following hold:
- ex_valid=1, ex_mem_read=1 and ex_rd_addr!=0;
- id_valid=1;
- ex_rd_addr equals id_rs1_addr or id_rs2_addr (conservative: compared even if the operand is unused).
REQ-015 SHALL, on each edge, apply the first matching case:
- rst: reset values;
- flush=1: load a bubble;
- stall=1: hold;
- id_hold=1: load a bubble;
- otherwise: load from ID.
REQ-016 SHALL define a bubble as: ex_valid=0, ex_reg_write=0, ex_mem_read=0, alu_ctrl=ADD (4'b0000), all data, address and select fields 0.
REQ-017 SHALL, during hold (stall=1 without flush), keep all control fields and replace the stored rs1/rs2 data with their current forwarded values, so that a WB result retiring during the stall is not lost.
REQ-018 SHALL treat flush and stall asserted together as flush.
REQ-019 SHALL load ID fields with ex_valid=0 when id_valid=0, and also clear reg_write and mem_read.
REQ-020 SHALL not gate id_hold with stall or flush; the controller arbitrates these.

Reset
REQ-021 SHALL, on rst=1 at an edge, load the bubble state: all outputs 0, ex_alu_ctrl=ADD, id_hold=0.
REQ-022 SHALL give rst priority over flush, stall and load-use in the same cycle.
REQ-023 SHALL, on a reset asserted mid-stall, discard the held instruction and retain no forwarded data.

Structure
REQ-024 SHALL take the ALU control enumeration (ADD 0000, SUB 0001, XOR 0010, OR 0011, AND 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001, THRU 1111), the src-select constants and the bubble constant from shared package rv32i_pkg; ALU and this stage SHALL both import it.
REQ-025 SHALL implement operand forwarding in one sub-module, fwd_mux (address, stored data, MEM/WB sources -> operand), instantiated twice.
REQ-026 SHALL contain no latches; the stage register SHALL be a single clocked process.

Verification
REQ-027 Plain load: id rs1_data=5, imm=7, src2_sel=1, alu_ctrl=ADD, no forwarding -> next cycle ex_src1=5, ex_src2=7, ex_valid=1.
REQ-028 Forward priority: ex rs1=x3 with mem_fwd(x3, 0xAAAA) and wb_fwd(x3, 0xBBBB) both active -> ex_src1=0xAAAA; drop mem_fwd_we -> 0xBBBB.
REQ-029 x0 rule: rs2=x0, registered data 0x1234, mem_fwd(x0, 0xFFFF) active -> ex_store_data=0.
REQ-030 Load-use: ex holds a load to x5 and ID reads x5 -> id_hold=1; next edge ex_valid=0 with reg_write=0; the following edge loads the held instruction.
REQ-031 Stall refresh: stall 2 cycles while wb_fwd(x7, 0x55) is present only in the first -> after the stall ex rs1(x7) operand=0x55.
REQ-032 Flush+stall and reset: flush=stall=1 -> bubble; rst=1 together with flush -> all outputs 0, ex_alu_ctrl=0000.
